// File: rtl/core_bus_router.sv
// core_bus_router: accepts one decoded request, strobes the address-selected core, waits for its ack
// (with timeout) and returns one registered result. Optional broadcast via CORE_ROUTER_BROADCAST_EN.
module core_bus_router #(
  parameter int         NUM_CORES    = 4,
  parameter int         SPAN_LOG2    = 4,
  parameter int         TIMEOUT      = 255,
  parameter logic [7:0] BCAST_OPCODE = 8'hFF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [7:0]              instruction_i,
  input  logic [23:0]             address_i,
  input  logic [31:0]             value_i,
  output logic                    resp_valid_o,
  output logic [31:0]             result_o,
  output logic                    resp_err_o,
  output logic                    busy_o,
  output logic [NUM_CORES-1:0]    core_valid_o,
  output logic [7:0]              core_instruction_o,
  output logic [23:0]             core_address_o,
  output logic [31:0]             core_value_o,
  input  logic [NUM_CORES-1:0]    core_ack_i,
  input  logic [32*NUM_CORES-1:0] core_result_i
);

  localparam int          CNT_W      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [23:0] LOCAL_MASK = 24'((32'd1 << SPAN_LOG2) - 32'd1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_CORES-1:0] r_core_valid;
  logic [7:0]           r_core_instruction;
  logic [23:0]          r_core_address;
  logic [31:0]          r_core_value;
  logic                 r_resp_valid;
  logic                 r_resp_err;
  logic [31:0]          r_result;

  logic [23:0]          w_idx;
  logic                 w_in_range;
  logic [NUM_CORES-1:0] w_sel;
  logic [NUM_CORES-1:0] w_launch;
  logic                 w_go_wait;
  logic [NUM_CORES-1:0] w_ack_hit;
  logic [NUM_CORES-1:0] w_remaining;
  logic [31:0]          w_hit_result;
  logic [31:0]          w_final_result;
  logic                 w_done;
  logic                 w_timeout;

  assign w_idx      = address_i >> SPAN_LOG2;
  assign w_in_range = (w_idx < 24'(NUM_CORES));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      assign w_sel[gi]     = (w_idx == 24'(gi));
      assign w_ack_hit[gi] = core_ack_i[gi] & r_core_valid[gi];
    end
  endgenerate

  // Only acks from cores currently strobed contribute; stray acks are masked out here.
  always_comb begin
    w_hit_result = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (w_ack_hit[n]) w_hit_result = w_hit_result | core_result_i[32*n +: 32];
    end
  end

  assign w_remaining = r_core_valid & ~core_ack_i;
  assign w_done      = ~|w_remaining;
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT));

`ifdef CORE_ROUTER_BROADCAST_EN
  logic        w_bcast;
  logic [31:0] r_acc;
  assign w_bcast        = (instruction_i == BCAST_OPCODE);
  assign w_launch       = w_bcast ? {NUM_CORES{1'b1}} : w_sel;
  assign w_go_wait      = w_bcast | w_in_range;
  assign w_final_result = r_acc | w_hit_result;
`else
  assign w_launch       = w_sel;
  assign w_go_wait      = w_in_range;
  assign w_final_result = w_hit_result;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state            <= S_IDLE;
      r_cnt              <= '0;
      r_core_valid       <= '0;
      r_core_instruction <= '0;
      r_core_address     <= '0;
      r_core_value       <= '0;
      r_resp_valid       <= 1'b0;
      r_resp_err         <= 1'b0;
      r_result           <= '0;
`ifdef CORE_ROUTER_BROADCAST_EN
      r_acc              <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_core_instruction <= instruction_i;
            r_core_address     <= address_i & LOCAL_MASK;
            r_core_value       <= value_i;
            r_cnt              <= '0;
`ifdef CORE_ROUTER_BROADCAST_EN
            r_acc              <= '0;
`endif
            if (w_go_wait) begin
              r_core_valid <= w_launch;
              r_state      <= S_WAIT;
            end else begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_result     <= '0;
              r_state      <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          // Each strobe drops as soon as its own core acks.
          r_core_valid <= w_remaining;
`ifdef CORE_ROUTER_BROADCAST_EN
          r_acc        <= r_acc | w_hit_result;
`endif
          if (w_done) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_result     <= w_final_result;
            r_core_valid <= '0;
            r_state      <= S_RESP;
          end else if (w_timeout) begin
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_result     <= '0;
            r_core_valid <= '0;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o        = (r_state == S_IDLE);
  assign busy_o             = (r_state != S_IDLE);
  assign resp_valid_o       = r_resp_valid;
  assign resp_err_o         = r_resp_err;
  assign result_o           = r_result;
  assign core_valid_o       = r_core_valid;
  assign core_instruction_o = r_core_instruction;
  assign core_address_o     = r_core_address;
  assign core_value_o       = r_core_value;

endmodule

// File: tb/tb_core_bus_router.sv
// Self-checking bench for core_bus_router: directed cases plus randomized transactions scored
// against an address/latency model. Broadcast case is built when CORE_ROUTER_BROADCAST_EN is defined.
module tb_core_bus_router;

  localparam int NC = 4;
  localparam int SL = 4;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [7:0]      instruction_i;
  logic [23:0]     address_i;
  logic [31:0]     value_i;
  logic            resp_valid_o;
  logic [31:0]     result_o;
  logic            resp_err_o;
  logic            busy_o;
  logic [NC-1:0]   core_valid_o;
  logic [7:0]      core_instruction_o;
  logic [23:0]     core_address_o;
  logic [31:0]     core_value_o;
  logic [NC-1:0]   core_ack_i;
  logic [32*NC-1:0] core_result_i;

  int n_checks = 0;
  int n_fail   = 0;

  core_bus_router #(
    .NUM_CORES(NC), .SPAN_LOG2(SL), .TIMEOUT(TO), .BCAST_OPCODE(8'hFF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .instruction_i(instruction_i), .address_i(address_i), .value_i(value_i),
    .resp_valid_o(resp_valid_o), .result_o(result_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o), .core_valid_o(core_valid_o),
    .core_instruction_o(core_instruction_o), .core_address_o(core_address_o),
    .core_value_o(core_value_o), .core_ack_i(core_ack_i), .core_result_i(core_result_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction: the model predicts routing, result, error and latency from the address and
  // the chosen ack delay (WAIT-cycle index at which the selected core acks; > TO means never).
  task automatic run_txn(input logic [23:0] addr, input logic [7:0] op, input logic [31:0] val,
                         input int ack_delay, input logic [31:0] ack_res, input bit noise);
    int            idx;
    bit            in_rng;
    logic [31:0]   exp_res;
    bit            exp_err;
    int            exp_lat;
    logic [NC-1:0] exp_sel;
    logic [23:0]   exp_loc;
    bit            seen;
    int            cyc;
    idx     = int'(addr >> SL);
    in_rng  = (idx < NC);
    exp_loc = addr & ((24'd1 << SL) - 24'd1);
    exp_sel = '0;
    if (in_rng) exp_sel[idx] = 1'b1;
    if (!in_rng) begin
      exp_err = 1'b1; exp_res = 32'h0; exp_lat = 1;
    end else if (ack_delay <= TO) begin
      exp_err = 1'b0; exp_res = ack_res; exp_lat = ack_delay + 2;
    end else begin
      exp_err = 1'b1; exp_res = 32'h0; exp_lat = TO + 2;
    end

    check("ready_idle", req_ready_o, 1);
    instruction_i = op; address_i = addr; value_i = val; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    seen = 1'b0;
    cyc  = 1;
    while (cyc <= TO + 4 && !seen) begin
      if (resp_valid_o) begin
        seen = 1'b1;
      end else begin
        check("core_valid", core_valid_o, exp_sel);
        check("core_addr", core_address_o, exp_loc);
        check("core_instr", core_instruction_o, op);
        check("core_value", core_value_o, val);
        check("busy_wait", busy_o, 1);
        check("ready_wait", req_ready_o, 0);
        core_ack_i = '0;
        if (noise) begin
          // Other cores ack with junk and a new request is presented; both must be ignored.
          core_ack_i    = ~exp_sel;
          core_result_i = {$urandom(), $urandom(), $urandom(), $urandom()};
          req_valid_i   = 1'b1;
          instruction_i = 8'($urandom());
          address_i     = 24'($urandom());
          value_i       = $urandom();
        end
        if (in_rng && (cyc - 1) == ack_delay) begin
          core_ack_i[idx] = 1'b1;
          core_result_i[32*idx +: 32] = ack_res;
        end
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    req_valid_i = 1'b0;
    core_ack_i  = '0;
    check("resp_seen", seen, 1);
    check("latency", cyc, exp_lat);
    if (seen) begin
      check("result", result_o, exp_res);
      check("resp_err", resp_err_o, exp_err);
      check("core_valid_resp", core_valid_o, 0);
      check("busy_resp", busy_o, 1);
      @(posedge clk_i); #1;
      check("resp_pulse", resp_valid_o, 0);
      check("result_hold", result_o, exp_res);
      check("ready_after", req_ready_o, 1);
      check("busy_after", busy_o, 0);
    end
    $display("txn addr=%06h op=%02h delay=%0d noise=%0d lat=%0d result=%08h err=%0d",
             addr, op, ack_delay, noise, cyc, result_o, resp_err_o);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; instruction_i = '0; address_i = '0; value_i = '0;
    core_ack_i = '0; core_result_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_err", resp_err_o, 0);
    check("rst_result", result_o, 0);
    check("rst_core_valid", core_valid_o, 0);
    check("rst_core_instr", core_instruction_o, 0);
    check("rst_core_addr", core_address_o, 0);
    check("rst_core_value", core_value_o, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      check("idle_ready", req_ready_o, 1);
      check("idle_core_valid", core_valid_o, 0);
      check("idle_resp_valid", resp_valid_o, 0);
    end

    run_txn(24'h000012, 8'h21, 32'h1111_2222, 3, 32'hCAFE_F00D, 1'b0);
    run_txn(24'h000040, 8'h22, 32'h3333_4444, 0, 32'h0, 1'b0);
    run_txn(24'h000005, 8'h23, 32'h5555_6666, TO + 5, 32'h0, 1'b0);
    run_txn(24'h000003, 8'h24, 32'h7777_8888, 4, 32'h0BAD_BEEF, 1'b1);
    run_txn(24'h000031, 8'h25, 32'h9999_AAAA, 0, 32'h1234_5678, 1'b0);
    run_txn(24'h000027, 8'h26, 32'hBBBB_CCCC, TO, 32'h8765_4321, 1'b1);
    run_txn(24'hFFFFFF, 8'h27, 32'hDDDD_EEEE, 1, 32'h1, 1'b1);

    // Reset while a transaction is waiting: strobe clears at once and no response follows.
    instruction_i = 8'h5A; address_i = 24'h000025; value_i = 32'hFEED_0001; req_valid_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("mid_core_valid", core_valid_o, 4'b0100);
    rst_i = 1'b1;
    #1;
    check("abort_core_valid", core_valid_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_ready", req_ready_o, 1);
    check("abort_result", result_o, 0);
    check("abort_core_instr", core_instruction_o, 0);
    check("abort_core_addr", core_address_o, 0);
    check("abort_core_value", core_value_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check("abort_no_resp", resp_valid_o, 0);
    end

`ifdef CORE_ROUTER_BROADCAST_EN
    begin
      int            dly[NC];
      logic [NC-1:0] exp_mask;
      bit            seen;
      int            cyc;
      dly[0] = 1; dly[1] = 3; dly[2] = 2; dly[3] = 5;
      instruction_i = 8'hFF; address_i = 24'hFFFFF0; value_i = 32'hB0B0_B0B0; req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      seen = 1'b0;
      cyc  = 1;
      while (cyc <= TO + 4 && !seen) begin
        if (resp_valid_o) begin
          seen = 1'b1;
        end else begin
          for (int n = 0; n < NC; n++) exp_mask[n] = ((cyc - 1) <= dly[n]);
          check("bcast_valid", core_valid_o, exp_mask);
          core_ack_i = '0;
          for (int n = 0; n < NC; n++) begin
            if ((cyc - 1) == dly[n]) begin
              core_ack_i[n] = 1'b1;
              core_result_i[32*n +: 32] = 32'd1 << n;
            end
          end
          @(posedge clk_i); #1;
          cyc++;
        end
      end
      core_ack_i = '0;
      check("bcast_seen", seen, 1);
      check("bcast_latency", cyc, 7);
      check("bcast_result", result_o, 32'hF);
      check("bcast_err", resp_err_o, 0);
      $display("txn broadcast lat=%0d result=%08h err=%0d", cyc, result_o, resp_err_o);
      @(posedge clk_i); #1;
    end
`else
    run_txn(24'h000031, 8'hFF, 32'h0F0F_0F0F, 2, 32'h0000_ABCD, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [23:0] a;
      a = 24'($urandom_range(0, 32'h5F));
      if ($urandom_range(0, 3) == 0) a = 24'($urandom());
      run_txn(a, 8'($urandom_range(0, 254)), $urandom(), int'($urandom_range(0, TO + 3)),
              $urandom(), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
